// File: rtl/vertex_update_accum_pkg.sv
// Shared types for the vertex update accumulator: controller states,
// combine-operator encoding and the initialisation fill value.
package vertex_update_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MIN = 1'b1
  } op_e;

  // Every bit of the INIT word is the same, so callers replicate this bit to
  // any data width: 0 is the ADD identity, all-ones is the MIN identity.
  function automatic logic init_bit(op_e op);
    return (op == OP_MIN);
  endfunction

endpackage

// File: rtl/vu_combine.sv
// Operator ALU: folds an update value into the current vertex value.
module vu_combine
  import vertex_update_accum_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              op,
  input  logic [DATA_W-1:0] operand,
  input  logic [DATA_W-1:0] upd,
  output logic [DATA_W-1:0] result
);

  // ADD wraps modulo 2**DATA_W; MIN is an unsigned compare.
  always_comb begin
    result = operand + upd;
    if (op_e'(op) == OP_MIN) begin
      result = (upd < operand) ? upd : operand;
    end
  end

endmodule

// File: rtl/vertex_update_accum.sv
// Vertex update accumulator: sweeps an external RAM to the operator identity,
// then applies a stream of (address, value) updates as read-modify-write with
// a one-deep forwarding path so same-address updates run at full rate.
module vertex_update_accum
  import vertex_update_accum_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_start,
  input  logic              op_sel,
  input  logic              stop,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_data,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_r_addr,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic              ram_w_en,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              clear_done,
  output logic              drain_done,
  output logic              busy,
  output logic [31:0]       upd_count
);

  // Control state
  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic                s2_valid_q, s2_valid_d;
  logic                pw_valid_q, pw_valid_d;
  logic [31:0]         upd_count_q, upd_count_d;
  logic                clear_done_q, clear_done_d;
  logic                drain_done_q, drain_done_d;

  // Datapath registers: write stage and the previous-cycle write for forwarding
  logic [ADDR_W-1:0]   s2_addr_q, s2_addr_d;
  logic [DATA_W-1:0]   s2_data_q, s2_data_d;
  logic [ADDR_W-1:0]   pw_addr_q, pw_addr_d;
  logic [DATA_W-1:0]   pw_data_q, pw_data_d;

  logic                accept;
  logic                wr_clear;
  logic                wr_any;
  logic [DATA_W-1:0]   operand;
  logic [DATA_W-1:0]   combine_result;
  logic [DATA_W-1:0]   init_value;

  assign upd_ready  = (state_q == ST_RUN);
  assign accept     = upd_valid && upd_ready;
  assign wr_clear   = (state_q == ST_CLEAR);
  assign init_value = {DATA_W{init_bit(op_q)}};

  // The RAM read issued last cycle cannot see the write committed on the same
  // edge (read-before-write), so a same-address write from the previous cycle
  // is forwarded instead.
  assign operand = (pw_valid_q && (pw_addr_q == s2_addr_q)) ? pw_data_q : ram_dout;

  vu_combine #(
    .DATA_W (DATA_W)
  ) u_combine (
    .op      (op_q),
    .operand (operand),
    .upd     (s2_data_q),
    .result  (combine_result)
  );

  // Next-state and register-input logic for the controller and pipeline.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    op_d         = op_q;
    sweep_d      = sweep_q;
    s2_valid_d   = 1'b0;
    s2_addr_d    = upd_addr;
    s2_data_d    = upd_data;
    pw_valid_d   = s2_valid_q;
    pw_addr_d    = s2_addr_q;
    pw_data_d    = combine_result;
    upd_count_d  = upd_count_q + 32'(s2_valid_q);
    clear_done_d = 1'b0;
    drain_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d     = ST_CLEAR;
          op_d        = op_e'(op_sel);
          sweep_d     = '0;
          upd_count_d = '0;
        end
      end
      ST_CLEAR: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == '1) begin
          state_d      = ST_RUN;
          clear_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        s2_valid_d = accept;
        if (stop) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Any update still in the write stage is written during this cycle,
        // so the pipeline is empty by the next edge.
        state_d      = ST_IDLE;
        drain_done_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_ADD;
      sweep_q      <= '0;
      s2_valid_q   <= 1'b0;
      pw_valid_q   <= 1'b0;
      upd_count_q  <= '0;
      clear_done_q <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      sweep_q      <= sweep_d;
      s2_valid_q   <= s2_valid_d;
      pw_valid_q   <= pw_valid_d;
      upd_count_q  <= upd_count_d;
      clear_done_q <= clear_done_d;
      drain_done_q <= drain_done_d;
    end
  end

  // Address/data pipeline registers.
  always_ff @(posedge clk) begin
    // NOTE: these carry no reset; they are only consumed when the matching
    // valid flag (which is reset) is set, so resetting them buys nothing.
    s2_addr_q <= s2_addr_d;
    s2_data_q <= s2_data_d;
    pw_addr_q <= pw_addr_d;
    pw_data_q <= pw_data_d;
  end

  // RAM port drive; writes are squashed while reset is asserted so an
  // in-flight update or sweep write never lands on the reset edge.
  always_comb begin
    wr_any     = wr_clear || s2_valid_q;
    ram_en     = rst_n && (state_q != ST_IDLE);
    ram_w_en   = rst_n && wr_any;
    ram_r_addr = accept ? upd_addr : '0;
    ram_w_addr = '0;
    ram_din    = '0;
    if (ram_w_en) begin
      ram_w_addr = wr_clear ? sweep_q : s2_addr_q;
      ram_din    = wr_clear ? init_value : combine_result;
    end
  end

  assign clear_done = clear_done_q;
  assign drain_done = drain_done_q;
  assign busy       = (state_q != ST_IDLE);
  assign upd_count  = upd_count_q;

endmodule
